// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-wide RAM port arbiter: FSM states,
// transaction owner, mem_len codes and the default IO window base.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  // Number of byte transfers for a mem_len code; code 3 behaves as a word.
  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      LEN_B:        return 3'd1;
      LEN_H:        return 3'd2;
      LEN_W, 2'd3:  return 3'd4;
      default:      return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IF/MEM stages, the arbiter and the byte-wide RAM.
// slave: arbiter side. master: requesters plus RAM (testbench side).
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [31:0]       if_data;

  logic              mem_req;
  logic              mem_wr;
  logic [1:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;

  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_done, if_data,
    input  mem_req, mem_wr, mem_len, mem_addr, mem_wdata,
    output mem_done, mem_rdata,
    output ram_a, ram_wr, ram_dout,
    input  ram_din
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_done, if_data,
    output mem_req, mem_wr, mem_len, mem_addr, mem_wdata,
    input  mem_done, mem_rdata,
    input  ram_a, ram_wr, ram_dout,
    output ram_din
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between instruction fetch and
// the MEM stage (MEM wins), splitting each access into little-endian byte
// transfers and returning a registered one-cycle done pulse.
// Optional build macro MEM_ARB_IOBUF_EN adds io_buffer_full, which stalls
// stores into the IO window (addr >= IO_BASE) before each byte.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DEFAULT)
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
`ifdef MEM_ARB_IOBUF_EN
  input  logic io_buffer_full,
`endif
  mem_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  owner_e            own_q, own_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [2:0]        n_q, n_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic              io_full;
  logic              io_stall;
  logic [2:0]        cnt_inc;
  logic [1:0]        cap_lane;
  logic [7:0]        wbyte [4];
  logic [31:0]       data_cap;

`ifdef MEM_ARB_IOBUF_EN
  assign io_full = io_buffer_full;
`else
  assign io_full = 1'b0;
`endif

  // Only stores into the IO window wait for the external buffer.
  assign io_stall = io_full && wr_q && (addr_q >= IO_BASE);
  assign cnt_inc  = cnt_q + 3'd1;
  // While reading, the byte arriving on ram_din belongs to the previous address.
  assign cap_lane = 2'(cnt_q - 3'd1);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wbyte[gi]            = wdata_q[8*gi +: 8];
      assign data_cap[8*gi +: 8]  = (cap_lane == 2'(gi)) ? bus.ram_din : data_q[8*gi +: 8];
    end
  endgenerate

  // Write strobe is combinational so rdy and the IO stall can gate it in the same cycle.
  assign bus.ram_wr    = rdy && (state_q == ST_BUSY) && wr_q && !io_stall;
  assign bus.ram_a     = ram_a_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_data   = if_data_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.mem_rdata = mem_rdata_q;

  // Next-state: arbitration, byte sequencing, capture and done generation.
  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    n_d         = n_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    if_done_d   = if_done_q;
    mem_done_d  = mem_done_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;

    if (rdy) begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.mem_req) begin
            state_d    = ST_BUSY;
            own_d      = OWN_MEM;
            addr_d     = bus.mem_addr;
            wr_d       = bus.mem_wr;
            n_d        = len_to_n(bus.mem_len);
            wdata_d    = bus.mem_wdata;
            cnt_d      = 3'd0;
            data_d     = '0;
            ram_a_d    = bus.mem_addr;
            ram_dout_d = bus.mem_wdata[7:0];
          end else if (bus.if_req && !bus.if_flush) begin
            state_d = ST_BUSY;
            own_d   = OWN_IF;
            addr_d  = bus.if_addr;
            wr_d    = 1'b0;
            n_d     = 3'd4;
            wdata_d = '0;
            cnt_d   = 3'd0;
            data_d  = '0;
            ram_a_d = bus.if_addr;
          end
        end
        ST_BUSY: begin
          if (own_q == OWN_IF && bus.if_flush) begin
            // Abort the fetch; ram_a keeps the last issued address.
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
          end else if (wr_q) begin
            if (!io_stall) begin
              if (cnt_q == n_q - 3'd1) begin
                state_d    = ST_DONE;
                mem_done_d = 1'b1;
                cnt_d      = 3'd0;
              end else begin
                cnt_d      = cnt_inc;
                ram_a_d    = addr_q + ADDR_W'(cnt_inc);
                ram_dout_d = wbyte[cnt_inc[1:0]];
              end
            end
          end else begin
            cnt_d = cnt_inc;
            if (cnt_q != 3'd0) data_d = data_cap;
            if (cnt_inc < n_q) ram_a_d = addr_q + ADDR_W'(cnt_inc);
            if (cnt_q == n_q) begin
              state_d = ST_DONE;
              cnt_d   = 3'd0;
              if (own_q == OWN_IF) begin
                if_done_d = 1'b1;
                if_data_d = data_cap;
              end else begin
                mem_done_d  = 1'b1;
                mem_rdata_d = data_cap;
              end
            end
          end
        end
        ST_DONE: begin
          // Requests are ignored here so the requester can drop req.
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // State register; reset returns everything to idle with zeroed outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      own_q       <= OWN_IF;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      n_q         <= 3'd0;
      wdata_q     <= '0;
      cnt_q       <= 3'd0;
      data_q      <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      n_q         <= n_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a small byte RAM model.
// Cycle 0 is the cycle in which a request is first driven.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
`ifdef MEM_ARB_IOBUF_EN
  logic io_buffer_full;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .IO_BASE(32'h0003_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
`ifdef MEM_ARB_IOBUF_EN
    .io_buffer_full (io_buffer_full),
`endif
    .bus            (bus)
  );

  // Byte RAM: read data one cycle after the address; preload port for setup.
  logic [7:0]  ram [0:4095];
  logic        pre_we;
  logic [11:0] pre_a;
  logic [7:0]  pre_d;

  always @(posedge clk) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (bus.ram_wr) ram[bus.ram_a[11:0]] <= bus.ram_dout;
    bus.ram_din <= ram[bus.ram_a[11:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    pre_a  = a;
    pre_d  = d;
    pre_we = 1'b1;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  initial begin
    int md;
    int id;
    rst = 1'b1;
    rdy = 1'b1;
    pre_we = 1'b0;
    pre_a = '0;
    pre_d = '0;
`ifdef MEM_ARB_IOBUF_EN
    io_buffer_full = 1'b0;
`endif
    bus.if_req = 1'b0;  bus.if_addr = '0;  bus.if_flush = 1'b0;
    bus.mem_req = 1'b0; bus.mem_wr = 1'b0; bus.mem_len = LEN_B;
    bus.mem_addr = '0;  bus.mem_wdata = '0;
    cyc();
    poke(12'h100, 8'h13); poke(12'h101, 8'h00); poke(12'h102, 8'h00); poke(12'h103, 8'hEF);
    poke(12'h1FF, 8'h00);
    poke(12'h200, 8'h78); poke(12'h201, 8'h56); poke(12'h202, 8'h34); poke(12'h203, 8'h12);
    poke(12'h300, 8'h80); poke(12'h301, 8'hFF);
    settle();
    chk("reset ram_a", bus.ram_a, 32'h0);
    chk("reset ram_wr", 32'(bus.ram_wr), 32'h0);
    chk("reset ram_dout", 32'(bus.ram_dout), 32'h0);
    chk("reset if_done", 32'(bus.if_done), 32'h0);
    chk("reset mem_done", 32'(bus.mem_done), 32'h0);
    chk("reset if_data", bus.if_data, 32'h0);
    chk("reset mem_rdata", bus.mem_rdata, 32'h0);
    cyc();
    rst = 1'b0;

    // Word fetch at 0x100.
    cyc();
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    for (int c = 1; c <= 6; c++) begin
      cyc(); settle();
      if (c <= 4) chk($sformatf("fetch ram_a c%0d", c), bus.ram_a, 32'h100 + 32'(c - 1));
      chk($sformatf("fetch ram_wr c%0d", c), 32'(bus.ram_wr), 32'h0);
      chk($sformatf("fetch if_done c%0d", c), 32'(bus.if_done), (c == 6) ? 32'h1 : 32'h0);
      if (c == 6) begin
        chk("fetch if_data", bus.if_data, 32'hEF00_0013);
        bus.if_req = 1'b0;
      end
    end
    cyc(); settle();
    chk("fetch if_done c7", 32'(bus.if_done), 32'h0);

    // Simultaneous MEM word load and fetch: MEM first.
    cyc();
    bus.mem_req = 1'b1; bus.mem_wr = 1'b0; bus.mem_len = LEN_W; bus.mem_addr = 32'h200;
    bus.if_req = 1'b1;  bus.if_addr = 32'h100;
    md = 0; id = 0;
    for (int c = 1; c <= 20; c++) begin
      cyc(); settle();
      if (c == 1) chk("prio ram_a c1", bus.ram_a, 32'h200);
      if (c == 8) chk("prio ram_a c8", bus.ram_a, 32'h100);
      if (bus.mem_done) begin
        if (md == 0) md = c;
        chk("prio mem_rdata", bus.mem_rdata, 32'h1234_5678);
        bus.mem_req = 1'b0;
      end
      if (bus.if_done) begin
        if (id == 0) id = c;
        chk("prio if_data", bus.if_data, 32'hEF00_0013);
        bus.if_req = 1'b0;
      end
    end
    chk("prio mem_done cycle", 32'(md), 32'd6);
    chk("prio if_done cycle", 32'(id), 32'd13);

    // Half store at 0x1FF crossing into 0x200.
    cyc();
    bus.mem_req = 1'b1; bus.mem_wr = 1'b1; bus.mem_len = LEN_H;
    bus.mem_addr = 32'h1FF; bus.mem_wdata = 32'hAABB_CCDD;
    for (int c = 1; c <= 3; c++) begin
      cyc(); settle();
      chk($sformatf("store ram_wr c%0d", c), 32'(bus.ram_wr), (c <= 2) ? 32'h1 : 32'h0);
      chk($sformatf("store mem_done c%0d", c), 32'(bus.mem_done), (c == 3) ? 32'h1 : 32'h0);
      if (c == 1) begin
        chk("store ram_a c1", bus.ram_a, 32'h1FF);
        chk("store ram_dout c1", 32'(bus.ram_dout), 32'hDD);
      end
      if (c == 2) begin
        chk("store ram_a c2", bus.ram_a, 32'h200);
        chk("store ram_dout c2", 32'(bus.ram_dout), 32'hCC);
      end
      if (c == 3) bus.mem_req = 1'b0;
    end
    chk("store ram[1FF]", 32'(ram[12'h1FF]), 32'hDD);
    chk("store ram[200]", 32'(ram[12'h200]), 32'hCC);
    chk("store ram[201]", 32'(ram[12'h201]), 32'h56);
    chk("store ram[202]", 32'(ram[12'h202]), 32'h34);

    // Byte load of 0x80: upper bits zero.
    cyc();
    bus.mem_req = 1'b1; bus.mem_wr = 1'b0; bus.mem_len = LEN_B; bus.mem_addr = 32'h300;
    for (int c = 1; c <= 3; c++) begin
      cyc(); settle();
      if (c == 1) chk("bload ram_a c1", bus.ram_a, 32'h300);
      chk($sformatf("bload mem_done c%0d", c), 32'(bus.mem_done), (c == 3) ? 32'h1 : 32'h0);
      if (c == 3) begin
        chk("bload mem_rdata", bus.mem_rdata, 32'h0000_0080);
        bus.mem_req = 1'b0;
      end
    end

    // Fetch flushed in cycle 3, new fetch accepted in cycle 4.
    cyc();
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      if (c == 4) begin
        bus.if_flush = 1'b0;
        bus.if_addr  = 32'h100;
      end
      settle();
      if (c <= 3) chk($sformatf("flush ram_a c%0d", c), bus.ram_a, 32'h100 + 32'(c - 1));
      if (c == 4) chk("flush ram_a held c4", bus.ram_a, 32'h102);
      if (c == 5) chk("flush new ram_a c5", bus.ram_a, 32'h100);
      chk($sformatf("flush if_done c%0d", c), 32'(bus.if_done), (c == 10) ? 32'h1 : 32'h0);
      if (c == 3) bus.if_flush = 1'b1;
      if (c == 10) begin
        chk("flush if_data", bus.if_data, 32'hEF00_0013);
        bus.if_req = 1'b0;
      end
    end

    // rdy low in cycle 1 of a byte store freezes it and blocks ram_wr.
    cyc();
    bus.mem_req = 1'b1; bus.mem_wr = 1'b1; bus.mem_len = LEN_B;
    bus.mem_addr = 32'h310; bus.mem_wdata = 32'h0000_005A;
    cyc(); rdy = 1'b0; settle();
    chk("rdy ram_wr c1", 32'(bus.ram_wr), 32'h0);
    chk("rdy ram_a c1", bus.ram_a, 32'h310);
    cyc(); rdy = 1'b1; settle();
    chk("rdy ram_wr c2", 32'(bus.ram_wr), 32'h1);
    chk("rdy mem_done c2", 32'(bus.mem_done), 32'h0);
    cyc(); settle();
    chk("rdy mem_done c3", 32'(bus.mem_done), 32'h1);
    bus.mem_req = 1'b0;
    chk("rdy ram[310]", 32'(ram[12'h310]), 32'h5A);

`ifdef MEM_ARB_IOBUF_EN
    // IO store held off by io_buffer_full for cycles 1-3.
    cyc();
    bus.mem_req = 1'b1; bus.mem_wr = 1'b1; bus.mem_len = LEN_B;
    bus.mem_addr = 32'h0003_0000; bus.mem_wdata = 32'h0000_00A5;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      io_buffer_full = (c <= 3);
      settle();
      chk($sformatf("io ram_wr c%0d", c), 32'(bus.ram_wr), (c == 4) ? 32'h1 : 32'h0);
      chk($sformatf("io mem_done c%0d", c), 32'(bus.mem_done), (c == 5) ? 32'h1 : 32'h0);
      if (c == 5) bus.mem_req = 1'b0;
    end
    io_buffer_full = 1'b0;
`endif

    // rst in cycle 2 of a word load clears all outputs next cycle.
    cyc();
    bus.mem_req = 1'b1; bus.mem_wr = 1'b0; bus.mem_len = LEN_W; bus.mem_addr = 32'h200;
    cyc();
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0; bus.mem_req = 1'b0; settle();
    chk("rst ram_a", bus.ram_a, 32'h0);
    chk("rst ram_wr", 32'(bus.ram_wr), 32'h0);
    chk("rst mem_done", 32'(bus.mem_done), 32'h0);
    chk("rst if_done", 32'(bus.if_done), 32'h0);
    chk("rst mem_rdata", bus.mem_rdata, 32'h0);
    chk("rst if_data", bus.if_data, 32'h0);
    cyc(); settle();
    chk("rst idle ram_a", bus.ram_a, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
